// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter sharing one single-port L2 SRAM bank between several
// TCDM-style (req/gnt/rvalid) masters. One access per cycle is forwarded to the
// bank and the response is routed back to the granted master one cycle later.
module l2_bank_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 14
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_MASTERS-1:0]                m_req_i,
   output logic [NUM_MASTERS-1:0]                m_gnt_o,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
   output logic [NUM_MASTERS-1:0]                m_rvalid_o,
   output logic [DATA_WIDTH-1:0]                 m_rdata_o,
   output logic                                  mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0]             mem_addr_o,
   output logic                                  mem_we_o,
   output logic [DATA_WIDTH/8-1:0]               mem_be_o,
   output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
   output logic [31:0]                           conflict_cnt_o
);

   localparam int unsigned IdW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned BeW = DATA_WIDTH / 8;
   localparam logic [IdW:0]   NumM   = (IdW + 1)'(NUM_MASTERS);
   localparam logic [IdW-1:0] LastId = IdW'(NUM_MASTERS - 1);

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
   logic [BeW-1:0]        be_arr    [NUM_MASTERS];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

   logic [IdW-1:0] ptr_q, ptr_d;
   logic           resp_valid_q;
   logic [IdW-1:0] resp_id_q;
   logic [31:0]    cnt_q, cnt_d;

   logic           gnt_found;
   logic [IdW-1:0] gnt_id;
   logic [IdW-1:0] cand;
   logic [IdW:0]   sum;
   logic [IdW:0]   req_cnt;
   logic           contention;

   // Upper address bits are decoded upstream; only the word index is used here.
   logic unused_addr;
   assign unused_addr = ^m_addr_i;

   // Unpack the flat master buses into per-master arrays.
   always_comb begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         addr_arr[i]  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         be_arr[i]    = m_be_i[i*BeW +: BeW];
         wdata_arr[i] = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin pick: first requester at or above the pointer, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      sum       = '0;
      m_gnt_o   = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         sum = {1'b0, ptr_q} + (IdW + 1)'(i);
         if (sum >= NumM) begin
            sum = sum - NumM;
         end
         cand = sum[IdW-1:0];
         if (!gnt_found && m_req_i[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
      if (gnt_found) begin
         m_gnt_o[gnt_id] = 1'b1;
      end
   end

   // Steer the granted master's access onto the SRAM port.
   always_comb begin
      mem_req_o   = gnt_found;
      mem_we_o    = gnt_found & m_we_i[gnt_id];
      mem_be_o    = be_arr[gnt_id];
      mem_wdata_o = wdata_arr[gnt_id];
      mem_addr_o  = addr_arr[gnt_id][MEM_ADDR_WIDTH+1:2];
   end

   // Next pointer and saturating contention count.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      req_cnt = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         req_cnt = req_cnt + (IdW + 1)'(m_req_i[i]);
      end
      contention = (req_cnt >= (IdW + 1)'(2));
      if (gnt_found) begin
         ptr_d = (gnt_id == LastId) ? '0 : gnt_id + 1'b1;
      end
      if (contention && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // State registers; reset also drops any response in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         cnt_q        <= '0;
      end else begin
         ptr_q        <= ptr_d;
         resp_valid_q <= gnt_found;
         resp_id_q    <= gnt_id;
         cnt_q        <= cnt_d;
      end
   end

   // Route the single-cycle-latency response back to the owning master.
   always_comb begin
      m_rvalid_o = '0;
      if (resp_valid_q) begin
         m_rvalid_o[resp_id_q] = 1'b1;
      end
      m_rdata_o      = mem_rdata_i;
      conflict_cnt_o = cnt_q;
   end

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed bench for l2_bank_arbiter with a small SRAM stand-in and a
// scoreboard of expected responses, one entry per clock cycle.
module tb_l2_bank_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   req, we, gnt, rvalid;
   logic [127:0] addr, wdata;
   logic [15:0]  be;
   logic [31:0]  rdata;
   logic         mem_req, mem_we;
   logic [13:0]  mem_addr;
   logic [3:0]   mem_be;
   logic [31:0]  mem_wdata, mem_rdata, cnt;

   l2_bank_arbiter #(
      .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(14)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(req), .m_gnt_o(gnt), .m_addr_i(addr), .m_we_i(we), .m_be_i(be),
      .m_wdata_i(wdata), .m_rvalid_o(rvalid), .m_rdata_o(rdata),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
   );

   // SRAM stand-in: preloaded while reset is high, one-cycle read latency.
   logic [31:0] sram [0:16383];
   always @(posedge clk) begin
      if (rst) begin
         sram[4] <= 32'hDEAD_BEEF;
         sram[2] <= 32'hAABB_CCDD;
      end else if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   typedef struct packed {
      logic [3:0]  rv;
      logic [31:0] data;
      logic        chk;
   } resp_t;

   resp_t       sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_cnt = 32'd0;

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s: got %08h expected %08h", tag, what, obs, exp);
      end
   endtask

   task automatic drive_m(input int k, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
      addr[k*32 +: 32]  = a;
      we[k]             = w;
      be[k*4 +: 4]      = b;
      wdata[k*32 +: 32] = d;
   endtask

   // Check one cycle at the falling edge, then queue the response it should cause.
   task automatic cycle(input string tag, input logic [3:0] egnt, input logic chk_mem,
                        input logic [13:0] eaddr, input logic ewe, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic erd_chk);
      resp_t e;
      @(negedge clk);
      chk(tag, "gnt", 32'(gnt), 32'(egnt));
      chk(tag, "mem_req", 32'(mem_req), 32'(egnt != 4'b0));
      if (chk_mem) begin
         chk(tag, "mem_addr", 32'(mem_addr), 32'(eaddr));
         chk(tag, "mem_we", 32'(mem_we), 32'(ewe));
         chk(tag, "mem_be", 32'(mem_be), 32'(ebe));
         chk(tag, "mem_wdata", mem_wdata, ewd);
      end
      chk(tag, "sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(tag, "rvalid", 32'(rvalid), 32'(e.rv));
         if (e.chk) chk(tag, "rdata", rdata, e.data);
      end
      chk(tag, "conflict_cnt", cnt, exp_cnt);
      e = '{rv: (rst ? 4'b0 : egnt), data: erd, chk: (erd_chk && !rst)};
      sb.push_back(e);
      if (rst) exp_cnt = 32'd0;
      else if ($countones(req) >= 2 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = '0; we = '0; be = '1; addr = '0; wdata = '0;
      @(posedge clk);
      #1;
      sb.push_back('{rv: 4'b0, data: 32'h0, chk: 1'b0});

      // Reset then idle
      cycle("reset", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      cycle("idle0", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      cycle("idle1", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      // Single read by master 2 of word 4
      drive_m(2, 32'h1C00_0010, 1'b0, 4'hF, 32'h0);
      req = 4'b0100;
      cycle("rd_gnt", 4'b0100, 1'b1, 14'd4, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
      req = 4'b0000;
      cycle("rd_resp", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      // Full contention held through a reset; pointer is 3 while reset is high
      for (int k = 0; k < 4; k++) drive_m(k, 32'h100 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
      req = 4'b1111;
      rst = 1'b1;
      cycle("fc_rst", 4'b1000, 1'b1, 14'h43, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle("fc", 4'(1 << (i % 4)), 1'b1, 14'(32'h40 + 32'(i % 4)), 1'b0, 4'hF,
               32'h0, 32'h0, 1'b0);
      end

      // Pointer skip: last grant went to master 1
      req = 4'b1001;
      cycle("skip3", 4'b1000, 1'b1, 14'h43, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      req = 4'b0001;
      cycle("skip0", 4'b0001, 1'b1, 14'h40, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);

      // Partial write by master 0, then read-back of the merged word
      drive_m(0, 32'h8, 1'b1, 4'b0011, 32'h1122_3344);
      cycle("wr", 4'b0001, 1'b1, 14'd2, 1'b1, 4'b0011, 32'h1122_3344, 32'h0, 1'b0);
      drive_m(0, 32'h8, 1'b0, 4'hF, 32'h0);
      cycle("rb", 4'b0001, 1'b1, 14'd2, 1'b0, 4'hF, 32'h0, 32'hAABB_3344, 1'b1);
      req = 4'b0000;
      cycle("rb_resp", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      // Reset mid-transfer: grant to 3, then a reset cycle that also grants 1
      drive_m(3, 32'h1C, 1'b0, 4'hF, 32'h0);
      req = 4'b1000;
      cycle("mid_g3", 4'b1000, 1'b1, 14'd7, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      req = 4'b0010;
      cycle("mid_rst", 4'b0010, 1'b1, 14'h41, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      req = 4'b1001;
      cycle("mid_ptr", 4'b0001, 1'b1, 14'd2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      req = 4'b0000;
      cycle("mid_r1", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      cycle("mid_r2", 4'b0000, 1'b0, 14'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
